hazard_ctrl_mc: RTL and testbench

- Next-generation hazard/forwarding controller for the RVX10 five-stage pipeline.
- Generalises the E-stage operand bypass to a parametrised register-file size.
- Adds load-use stall detection and taken-branch flush.
- Adds a sequenced multicycle-execute hold: a counter keeps a long-latency RVX10 op in E for MC_LAT cycles, bubbling M behind it.

---
 rtl/hazard_ctrl_mc_pkg.sv | 15 +
 rtl/hazard_ctrl_mc_if.sv | 33 +++
 rtl/hazard_ctrl_mc_fwd_select.sv | 25 ++
 rtl/hazard_ctrl_mc.sv | 97 +++++++++
 tb/tb_hazard_ctrl_mc.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_mc_pkg.sv
// Shared types for the RVX10 hazard/forwarding controller.
package rvx10_hz_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_M  = 2'b01,
        FWD_W  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_t;

endpackage

// File: rtl/hazard_ctrl_mc_if.sv
// Pipeline <-> hazard unit signal bundle; master is the pipeline, slave the controller.
interface hazard_ctrl_mc_if
#(
    parameter int unsigned NREG = 32
);
    import rvx10_hz_pkg::*;

    localparam int unsigned AW = $clog2(NREG);

    logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E;
    logic [AW-1:0] RdE, RdM, RdW;
    logic          RegWriteM, RegWriteW;
    logic          LoadE, PCSrcE, McStartE;
    fwd_sel_t      ForwardAE, ForwardBE;
    logic          StallF, StallD, StallE;
    logic          FlushD, FlushE, FlushM;
    logic          McBusy, McDone;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, LoadE, PCSrcE, McStartE,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE,
        input  FlushD, FlushE, FlushM, McBusy, McDone
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, LoadE, PCSrcE, McStartE,
        output ForwardAE, ForwardBE, StallF, StallD, StallE,
        output FlushD, FlushE, FlushM, McBusy, McDone
    );

endinterface

// File: rtl/hazard_ctrl_mc_fwd_select.sv
// Per-operand bypass selector: M result wins over W; x0 never forwarded.
module fwd_select
    import rvx10_hz_pkg::*;
#(
    parameter int unsigned AW = 5
)
(
    input  logic [AW-1:0] i_rs,
    input  logic [AW-1:0] i_rd_m,
    input  logic [AW-1:0] i_rd_w,
    input  logic          i_we_m,
    input  logic          i_we_w,
    output fwd_sel_t      o_sel
);

    always_comb begin
        o_sel = FWD_RF;
        if (i_we_m && (i_rd_m != '0) && (i_rd_m == i_rs)) begin
            o_sel = FWD_M;
        end else if (i_we_w && (i_rd_w != '0) && (i_rd_w == i_rs)) begin
            o_sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// RVX10 hazard controller: E-stage bypass, load-use stall, branch flush and
// a counter-sequenced hold that keeps a multicycle op in E for MC_LAT cycles.
module hazard_ctrl_mc
    import rvx10_hz_pkg::*;
#(
    parameter int unsigned NREG   = 32,
    parameter int unsigned MC_LAT = 4
)
(
    input  logic         clk,
    input  logic         reset_n,
    hazard_ctrl_mc_if.slave hz
);

    localparam int unsigned AW = $clog2(NREG);
    localparam int unsigned CW = $clog2(MC_LAT + 1);

    mc_state_t     r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          w_mc_stall, w_mc_done, w_lw_stall;

    fwd_select #(.AW(AW)) u_fwd_a (
        .i_rs   (hz.Rs1E),
        .i_rd_m (hz.RdM),
        .i_rd_w (hz.RdW),
        .i_we_m (hz.RegWriteM),
        .i_we_w (hz.RegWriteW),
        .o_sel  (hz.ForwardAE)
    );

    fwd_select #(.AW(AW)) u_fwd_b (
        .i_rs   (hz.Rs2E),
        .i_rd_m (hz.RdM),
        .i_rd_w (hz.RdW),
        .i_we_m (hz.RegWriteM),
        .i_we_w (hz.RegWriteW),
        .o_sel  (hz.ForwardBE)
    );

    assign w_lw_stall = hz.LoadE && (hz.RdE != '0) &&
                        ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= MC_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // McStartE is not looked at in BUSY: the same op is still sitting in E.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mc_stall  = 1'b0;
        w_mc_done   = 1'b0;
        case (r_state)
            MC_IDLE: begin
                if (hz.McStartE) begin
                    if (MC_LAT > 1) begin
                        w_mc_stall  = 1'b1;
                        w_state_nxt = MC_BUSY;
                        w_cnt_nxt   = CW'(MC_LAT - 1);
                    end else begin
                        w_mc_done = 1'b1;
                    end
                end
            end
            MC_BUSY: begin
                w_mc_stall = (r_cnt != CW'(1));
                w_mc_done  = (r_cnt == CW'(1));
                w_cnt_nxt  = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = MC_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = MC_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Combinational terms are gated so every control output is low while in reset.
    assign hz.StallF = reset_n & (w_lw_stall | w_mc_stall);
    assign hz.StallD = reset_n & (w_lw_stall | w_mc_stall);
    assign hz.StallE = reset_n & w_mc_stall;
    assign hz.FlushM = reset_n & w_mc_stall;
    assign hz.FlushD = reset_n & hz.PCSrcE & ~w_mc_stall;
    assign hz.FlushE = reset_n & (w_lw_stall | hz.PCSrcE) & ~w_mc_stall;
    assign hz.McBusy = (r_state == MC_BUSY);
    assign hz.McDone = reset_n & w_mc_done;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed bench for hazard_ctrl_mc: forwarding, load-use, branch flush and
// multicycle hold sequencing (MC_LAT=4 main instance, MC_LAT=1 side instance).
module tb_hazard_ctrl_mc;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    hazard_ctrl_mc_if #(.NREG(32)) hz ();
    hazard_ctrl_mc_if #(.NREG(32)) hz1 ();

    hazard_ctrl_mc #(.NREG(32), .MC_LAT(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (hz)
    );

    hazard_ctrl_mc #(.NREG(32), .MC_LAT(1)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (hz1)
    );

    task automatic clear_inputs();
        hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0;
        hz.RdE = '0; hz.RdM = '0; hz.RdW = '0;
        hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
        hz.LoadE = 1'b0; hz.PCSrcE = 1'b0; hz.McStartE = 1'b0;
        hz1.Rs1D = '0; hz1.Rs2D = '0; hz1.Rs1E = '0; hz1.Rs2E = '0;
        hz1.RdE = '0; hz1.RdM = '0; hz1.RdW = '0;
        hz1.RegWriteM = 1'b0; hz1.RegWriteW = 1'b0;
        hz1.LoadE = 1'b0; hz1.PCSrcE = 1'b0; hz1.McStartE = 1'b0;
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] ctl;
        clear_inputs();
        hz.LoadE = 1'b1; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
        hz.PCSrcE = 1'b1; hz.McStartE = 1'b1;
        hz.Rs1E = 5'd5; hz.RdM = 5'd5; hz.RegWriteM = 1'b1;
        hz1.McStartE = 1'b1;
        #2;
        ctl = {hz.StallF, hz.StallD, hz.StallE, hz.FlushD, hz.FlushE,
               hz.FlushM, hz.McBusy, hz.McDone, hz1.McDone, hz1.McBusy};
        checks++;
        if (ctl !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", ctl, 10'b0);
        end
        checks++;
        if (hz.ForwardAE !== 2'b01) begin
            errors++;
            $display("FAIL reset_fwd_comb: got %b expected 01", hz.ForwardAE);
        end
        step();
        clear_inputs();
        reset_n = 1'b1;
        #1;
        checks++;
        if (hz.McBusy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_busy: got %b expected 0", hz.McBusy);
        end
    endtask

    task automatic test_forward();
        // {Rs1E, Rs2E, RdM, RdW, WeM, WeW, expA, expB}
        logic [4:0] rs1 [6] = '{5'd5, 5'd5, 5'd5, 5'd3, 5'd0, 5'd31};
        logic [4:0] rs2 [6] = '{5'd5, 5'd5, 5'd5, 5'd9, 5'd0, 5'd31};
        logic [4:0] rdm [6] = '{5'd5, 5'd0, 5'd5, 5'd3, 5'd0, 5'd31};
        logic [4:0] rdw [6] = '{5'd5, 5'd5, 5'd5, 5'd9, 5'd0, 5'd31};
        logic       wem [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic       wew [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [1:0] ea  [6] = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        logic [1:0] eb  [6] = '{2'b01, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10};
        for (int i = 0; i < 6; i++) begin
            hz.Rs1E = rs1[i]; hz.Rs2E = rs2[i]; hz.RdM = rdm[i]; hz.RdW = rdw[i];
            hz.RegWriteM = wem[i]; hz.RegWriteW = wew[i];
            #2;
            checks++;
            if (hz.ForwardAE !== ea[i] || hz.ForwardBE !== eb[i]) begin
                errors++;
                $display("FAIL fwd_vec%0d: got A=%b B=%b expected A=%b B=%b",
                         i, hz.ForwardAE, hz.ForwardBE, ea[i], eb[i]);
            end
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        logic [5:0] ctl;
        step();
        hz.LoadE = 1'b1; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
        #2;
        ctl = {hz.StallF, hz.StallD, hz.FlushE, hz.StallE, hz.FlushM, hz.FlushD};
        checks++;
        if (ctl !== 6'b111000) begin
            errors++;
            $display("FAIL lw_rs2: got %b expected 111000", ctl);
        end
        step();
        hz.LoadE = 1'b0;
        #2;
        ctl = {hz.StallF, hz.StallD, hz.FlushE, hz.StallE, hz.FlushM, hz.FlushD};
        checks++;
        if (ctl !== 6'b000000) begin
            errors++;
            $display("FAIL lw_one_cycle: got %b expected 000000", ctl);
        end
        step();
        hz.LoadE = 1'b1; hz.RdE = 5'd12; hz.Rs2D = 5'd0; hz.Rs1D = 5'd12;
        #2;
        checks++;
        if ({hz.StallF, hz.FlushE} !== 2'b11) begin
            errors++;
            $display("FAIL lw_rs1: got %b expected 11", {hz.StallF, hz.FlushE});
        end
        hz.RdE = 5'd0; hz.Rs1D = 5'd0;
        #2;
        checks++;
        if ({hz.StallF, hz.StallD, hz.FlushE} !== 3'b000) begin
            errors++;
            $display("FAIL lw_x0: got %b expected 000", {hz.StallF, hz.StallD, hz.FlushE});
        end
        clear_inputs();
    endtask

    task automatic test_branch();
        logic [5:0] ctl;
        step();
        hz.PCSrcE = 1'b1;
        #2;
        ctl = {hz.FlushD, hz.FlushE, hz.StallF, hz.StallD, hz.StallE, hz.FlushM};
        checks++;
        if (ctl !== 6'b110000) begin
            errors++;
            $display("FAIL branch_idle: got %b expected 110000", ctl);
        end
        clear_inputs();
    endtask

    // Op resident in E for 4 cycles; load-use at k=1, branch at k=2.
    task automatic test_mc_hold();
        logic       exp_stall [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic       exp_busy  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic       exp_done  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [4:0] got, exp;
        for (int k = 0; k < 4; k++) begin
            step();
            clear_inputs();
            hz.McStartE = 1'b1;
            if (k == 1) begin
                hz.LoadE = 1'b1; hz.RdE = 5'd7; hz.Rs1D = 5'd7;
            end
            if (k == 2) hz.PCSrcE = 1'b1;
            #2;
            got = {hz.StallF, hz.StallE, hz.FlushM, hz.McBusy, hz.McDone};
            exp = {exp_stall[k], exp_stall[k], exp_stall[k], exp_busy[k], exp_done[k]};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL mc_hold_k%0d: got %b expected %b", k, got, exp);
            end
            checks++;
            if ({hz.FlushD, hz.FlushE} !== 2'b00) begin
                errors++;
                $display("FAIL mc_hold_noflush_k%0d: got %b expected 00",
                         k, {hz.FlushD, hz.FlushE});
            end
        end
        step();
        clear_inputs();
        #2;
        checks++;
        if ({hz.McBusy, hz.McDone, hz.StallE} !== 3'b000) begin
            errors++;
            $display("FAIL mc_after: got %b expected 000", {hz.McBusy, hz.McDone, hz.StallE});
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] got, exp;
        for (int k = 0; k < 8; k++) begin
            step();
            hz.McStartE = 1'b1;
            #2;
            got = {hz.StallE, hz.McBusy, hz.McDone};
            exp = {((k % 4) != 3), ((k % 4) != 0), ((k % 4) == 3)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL b2b_k%0d: got %b expected %b", k, got, exp);
            end
        end
        clear_inputs();
    endtask

    task automatic test_mc_reset();
        logic [7:0] ctl;
        int         seen_done;
        step();
        hz.McStartE = 1'b1;
        step();
        #2;
        reset_n = 1'b0;
        #1;
        ctl = {hz.McBusy, hz.StallF, hz.StallD, hz.StallE,
               hz.FlushD, hz.FlushE, hz.FlushM, hz.McDone};
        checks++;
        if (ctl !== 8'b0) begin
            errors++;
            $display("FAIL mc_reset_async: got %b expected 00000000", ctl);
        end
        step();
        clear_inputs();
        reset_n = 1'b1;
        seen_done = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (hz.McDone !== 1'b0 || hz.McBusy !== 1'b0) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL mc_reset_idle: got %0d busy/done cycles expected 0", seen_done);
        end
    endtask

    task automatic test_mc_lat1();
        for (int k = 0; k < 2; k++) begin
            step();
            hz1.McStartE = 1'b1;
            #2;
            checks++;
            if ({hz1.McDone, hz1.McBusy, hz1.StallE, hz1.StallF} !== 4'b1000) begin
                errors++;
                $display("FAIL lat1_k%0d: got %b expected 1000", k,
                         {hz1.McDone, hz1.McBusy, hz1.StallE, hz1.StallF});
            end
        end
        hz1.McStartE = 1'b0;
        #1;
        checks++;
        if (hz1.McDone !== 1'b0) begin
            errors++;
            $display("FAIL lat1_off: got %b expected 0", hz1.McDone);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_mc_hold();
        test_back_to_back();
        test_mc_reset();
        test_mc_lat1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
